// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the multiplexed 7-segment scanner.
package seg_pkg;

    // Widest display the scanner supports; enable patterns are sliced from this.
    localparam int MAX_DIGITS = 8;

    // Common-anode enables are active-low, so "all off" is all ones.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = 8'hFF;

    // Decimal point pin is active-low as well.
    localparam logic DP_OFF = 1'b1;

    // Nibble presented to the segment decoder while nothing has been scanned yet.
    localparam logic [3:0] BLANK_NIBBLE = 4'h0;

    // Clock cycles in one complete scan frame.
    function automatic int frame_len(input int digits, input int pwm_bits, input int div);
        return digits * (32'd1 << pwm_bits) * div;
    endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// seg_lz_mask: flags leading-zero digits that should stay dark.
// A digit is "significant" when it is nonzero or carries a decimal point;
// everything above the highest significant digit is blanked, and the
// least significant digit is always shown so an all-zero value reads "0".
module seg_lz_mask
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dp,
    input  logic                blank_lz,
    output logic [DIGITS-1:0]   blank_mask
);

    logic [DIGITS-1:0] sig_s;
    logic [DIGITS-1:0] raw_mask_s;
    logic              leading_s;

    // Walk from the most significant digit down until a significant digit stops the blanking.
    always_comb begin
        sig_s      = {DIGITS{1'b0}};
        raw_mask_s = {DIGITS{1'b0}};
        leading_s  = blank_lz;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            sig_s[k] = (data[4*k +: 4] != 4'h0) || dp[k];
            if (leading_s && !sig_s[k]) begin
                raw_mask_s[k] = 1'b1;
            end else begin
                leading_s = 1'b0;
            end
        end
        // Digit 0 always survives so a zero value is still visible.
        blank_mask = raw_mask_s & ~{{(DIGITS-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed N-digit 7-segment driver with PWM brightness,
// leading-zero blanking, per-digit blink and frame-aligned shadow loading.
// fnum feeds the hex-to-segment decoder; an and point drive the pins directly.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PWM_BITS   = 4,
    parameter int DIV        = 1,
    parameter int BLINK_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [PWM_BITS-1:0]   bright,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [3:0]            fnum,
    output logic                  point,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [PWM_BITS-1:0] SLOT_LAST = {PWM_BITS{1'b1}};

    // Timebase and scan position
    logic [DIV_W-1:0]      div_cnt_q,   div_cnt_d;
    logic [PWM_BITS-1:0]   slot_cnt_q,  slot_cnt_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;

    // Pending (written by load) and active (displayed) shadows
    logic [4*DIGITS-1:0]   pend_data_q,  pend_data_d;
    logic [DIGITS-1:0]     pend_dp_q,    pend_dp_d;
    logic [DIGITS-1:0]     pend_blink_q, pend_blink_d;
    logic [4*DIGITS-1:0]   act_data_q,   act_data_d;
    logic [DIGITS-1:0]     act_dp_q,     act_dp_d;
    logic [DIGITS-1:0]     act_blink_q,  act_blink_d;

    // Registered outputs
    logic [DIGITS-1:0]     an_q,         an_d;
    logic [3:0]            fnum_q,       fnum_d;
    logic                  point_q,      point_d;
    logic                  frame_done_q, frame_done_d;

    // Decode helpers
    logic                  tick_s;
    logic                  slot_wrap_s;
    logic                  boundary_s;
    logic [DIGITS-1:0]     lz_mask_s;
    logic [3:0]            cur_digit_s;
    logic                  cur_dp_s;
    logic                  cur_blink_s;
    logic                  cur_lz_s;
    logic                  pwm_on_s;
    logic                  blink_off_s;
    logic                  lit_s;
    logic [DIGITS-1:0]     sel_s;

    seg_lz_mask #(
        .DIGITS     (DIGITS)
    ) u_lz_mask (
        .data       (act_data_q),
        .dp         (act_dp_q),
        .blank_lz   (blank_lz),
        .blank_mask (lz_mask_s)
    );

    // Prescaler, PWM slot counter, digit index and per-frame blink counter.
    always_comb begin
        tick_s      = (div_cnt_q == DIV_LAST);
        slot_wrap_s = tick_s && (slot_cnt_q == SLOT_LAST);
        boundary_s  = slot_wrap_s && (idx_q == IDX_LAST);

        if (tick_s) begin
            div_cnt_d  = {DIV_W{1'b0}};
            slot_cnt_d = slot_cnt_q + PWM_BITS'(1);
        end else begin
            div_cnt_d  = div_cnt_q + DIV_W'(1);
            slot_cnt_d = slot_cnt_q;
        end

        if (slot_wrap_s) begin
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end

        if (boundary_s) begin
            blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
        end else begin
            blink_cnt_d = blink_cnt_q;
        end

        frame_done_d = boundary_s;
    end

    // Shadow loading: content only swaps at the frame boundary, and a load in
    // that very cycle bypasses the pending copy so it is not delayed a frame.
    always_comb begin
        if (load) begin
            pend_data_d  = data;
            pend_dp_d    = dp_mask;
            pend_blink_d = blink_mask;
        end else begin
            pend_data_d  = pend_data_q;
            pend_dp_d    = pend_dp_q;
            pend_blink_d = pend_blink_q;
        end

        if (boundary_s) begin
            if (load) begin
                act_data_d  = data;
                act_dp_d    = dp_mask;
                act_blink_d = blink_mask;
            end else begin
                act_data_d  = pend_data_q;
                act_dp_d    = pend_dp_q;
                act_blink_d = pend_blink_q;
            end
        end else begin
            act_data_d  = act_data_q;
            act_dp_d    = act_dp_q;
            act_blink_d = act_blink_q;
        end
    end

    // Decide whether the current digit is lit and form the pin values.
    always_comb begin
        cur_digit_s = act_data_q[{idx_q, 2'b00} +: 4];
        cur_dp_s    = act_dp_q[idx_q];
        cur_blink_s = act_blink_q[idx_q];
        cur_lz_s    = lz_mask_s[idx_q];

        // Slot 0 always passes, so even the lowest brightness is never fully dark.
        pwm_on_s    = (slot_cnt_q <= bright);
        blink_off_s = blink_cnt_q[BLINK_BITS-1] && cur_blink_s;
        lit_s       = pwm_on_s && !cur_lz_s && !blink_off_s;

        sel_s        = {DIGITS{1'b0}};
        sel_s[idx_q] = 1'b1;

        // The decoder keeps seeing the digit value even while the digit is dark.
        fnum_d = cur_digit_s;

        if (lit_s) begin
            an_d    = ~sel_s;
            point_d = ~cur_dp_s;
        end else begin
            an_d    = AN_OFF[DIGITS-1:0];
            point_d = DP_OFF;
        end
    end

    // Scan counters and shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= {DIV_W{1'b0}};
            slot_cnt_q   <= {PWM_BITS{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            blink_cnt_q  <= {BLINK_BITS{1'b0}};
            pend_data_q  <= {(4*DIGITS){1'b0}};
            pend_dp_q    <= {DIGITS{1'b0}};
            pend_blink_q <= {DIGITS{1'b0}};
            act_data_q   <= {(4*DIGITS){1'b0}};
            act_dp_q     <= {DIGITS{1'b0}};
            act_blink_q  <= {DIGITS{1'b0}};
        end else begin
            div_cnt_q    <= div_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blink_q <= pend_blink_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blink_q  <= act_blink_d;
        end
    end

    // Output registers, one cycle behind the scan counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q         <= AN_OFF[DIGITS-1:0];
            fnum_q       <= BLANK_NIBBLE;
            point_q      <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            fnum_q       <= fnum_d;
            point_q      <= point_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign fnum       = fnum_q;
    assign point      = point_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (4 digits, 16 slots, DIV 1,
// 2-bit blink counter). Expected per-cycle pin values for whole frames are queued
// by the stimulus; a monitor pops and compares one entry every falling edge.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int FRAME = frame_len(4, 4, 1);
    localparam int SLOT  = 16;

    typedef struct {
        logic [3:0] an;
        logic [3:0] fnum;
        logic       point;
        logic       fd;
        int         pos;
        string      tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  bright;
    logic        blank_lz;
    logic        load;
    logic [3:0]  an;
    logic [3:0]  fnum;
    logic        point;
    logic        frame_done;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests;
    int   n_fail;
    int   fcount;

    seg_scan_ctrl #(
        .DIGITS     (4),
        .PWM_BITS   (4),
        .DIV        (1),
        .BLINK_BITS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .bright     (bright),
        .blank_lz   (blank_lz),
        .load       (load),
        .an         (an),
        .fnum       (fnum),
        .point      (point),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed frames since reset; frame after the k-th pulse has blink phase k[1].
    always @(negedge clk) begin
        if (rst) begin
            fcount = 0;
        end else if (frame_done === 1'b1) begin
            fcount = fcount + 1;
        end
    end

    // Monitor: one expected entry per cycle while the scoreboard is non-empty.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            n_tests = n_tests + 1;
            if (an !== mon_e.an || fnum !== mon_e.fnum || point !== mon_e.point ||
                frame_done !== mon_e.fd) begin
                n_fail = n_fail + 1;
                $display("FAIL %s pos=%0d: got an=%b fnum=%h point=%b fd=%b, want an=%b fnum=%h point=%b fd=%b",
                         mon_e.tag, mon_e.pos, an, fnum, point, frame_done,
                         mon_e.an, mon_e.fnum, mon_e.point, mon_e.fd);
            end
        end
    end

    // Queue one full frame of expected pins; dark marks digits blanked by LZ or blink.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp,
                              input logic [3:0] dark, input logic [3:0] br,
                              input string tag);
        exp_t e;
        int   k;
        int   s;
        logic lit;
        for (int p = 0; p < FRAME; p++) begin
            k      = p / SLOT;
            s      = p % SLOT;
            lit    = (s <= int'(br)) && !dark[k];
            e.an   = lit ? ~(4'b0001 << k) : 4'b1111;
            e.fnum = d[4*k +: 4];
            e.point = lit ? ~dp[k] : 1'b1;
            e.fd   = (p == FRAME - 1);
            e.pos  = p;
            e.tag  = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] e_an, input logic [3:0] e_fnum,
                             input logic e_point, input logic e_fd);
        n_tests = n_tests + 1;
        if (an !== e_an || fnum !== e_fnum || point !== e_point || frame_done !== e_fd) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got an=%b fnum=%h point=%b fd=%b, want an=%b fnum=%h point=%b fd=%b",
                     name, an, fnum, point, frame_done, e_an, e_fnum, e_point, e_fd);
        end
    endtask

    // Wait for the next frame_done pulse, returning the number of falling edges waited.
    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (frame_done !== 1'b1 && n < 300);
        if (frame_done !== 1'b1) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL frame_done_timeout: got no pulse in %0d cycles, want one within %0d", n, FRAME);
        end
        #1;
    endtask

    // Wait until the monitor has consumed every queued entry.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n = n + 1;
        end
        if (exp_q.size() != 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL drain_timeout: got %0d entries left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic load_pulse();
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Present new content, load it, and let the current frame run out.
    task automatic load_frame(input logic [15:0] d, input logic [3:0] dp,
                              input logic [3:0] bm, input logic blz);
        int n;
        data       = d;
        dp_mask    = dp;
        blink_mask = bm;
        blank_lz   = blz;
        load_pulse();
        wait_fd(n);
    endtask

    initial begin
        int          n;
        logic [3:0]  dark;
        n_tests    = 0;
        n_fail     = 0;
        fcount     = 0;
        rst        = 1'b1;
        data       = 16'h0000;
        dp_mask    = 4'h0;
        blink_mask = 4'h0;
        bright     = 4'h0;
        blank_lz   = 1'b0;
        load       = 1'b0;

        repeat (3) @(negedge clk);
        check_out("reset_values", 4'hF, 4'h0, 1'b1, 1'b0);

        // Basic scan at full brightness; the first frame still shows the zero shadow.
        #1;
        rst    = 1'b0;
        data   = 16'h1234;
        bright = 4'hF;
        load_pulse();
        wait_fd(n);
        n_tests = n_tests + 1;
        if (n != FRAME) begin
            n_fail = n_fail + 1;
            $display("FAIL first_frame_len: got %0d cycles, want %0d", n, FRAME);
        end
        push_frame(16'h1234, 4'h0, 4'h0, 4'hF, "t1_scan_full");
        drain();

        // Brightness takes effect without reloading.
        bright = 4'h3;
        push_frame(16'h1234, 4'h0, 4'h0, 4'h3, "t2_bright3");
        drain();
        bright = 4'h0;
        push_frame(16'h1234, 4'h0, 4'h0, 4'h0, "t2_bright0");
        drain();
        bright = 4'hF;

        // Leading-zero blanking variants.
        load_frame(16'h0050, 4'b0000, 4'b0000, 1'b1);
        push_frame(16'h0050, 4'b0000, 4'b1100, 4'hF, "t3_lz_0050");
        drain();
        load_frame(16'h0050, 4'b0100, 4'b0000, 1'b1);
        push_frame(16'h0050, 4'b0100, 4'b1000, 4'hF, "t3_lz_dp2");
        drain();
        load_frame(16'h0000, 4'b0000, 4'b0000, 1'b1);
        push_frame(16'h0000, 4'b0000, 4'b1110, 4'hF, "t3_lz_allzero");
        drain();
        load_frame(16'h1234, 4'b0000, 4'b0000, 1'b0);
        push_frame(16'h1234, 4'b0000, 4'b0000, 4'hF, "t3_lz_off");
        drain();

        // Load mid-frame: current frame keeps the old content.
        push_frame(16'h1234, 4'h0, 4'h0, 4'hF, "t5_old_kept");
        repeat (20) @(negedge clk);
        #1;
        data = 16'hABCD;
        load_pulse();
        drain();
        push_frame(16'hABCD, 4'h0, 4'h0, 4'hF, "t5_new_shown");
        repeat (63) @(negedge clk);
        // Load exactly in the boundary cycle goes straight to the active shadow.
        #1;
        data = 16'h5678;
        load_pulse();
        drain();
        push_frame(16'h5678, 4'h0, 4'h0, 4'hF, "t5_boundary_load");
        drain();
        push_frame(16'h5678, 4'h0, 4'h0, 4'hF, "t5_boundary_pending");
        drain();

        // Blink on digit 0 with a 2-bit frame counter.
        load_frame(16'h1234, 4'h0, 4'b0001, 1'b0);
        for (int f = 0; f < 4; f++) begin
            dark = ((fcount % 4) >= 2) ? 4'b0001 : 4'b0000;
            push_frame(16'h1234, 4'h0, dark, 4'hF, $sformatf("t4_blink_f%0d", fcount % 4));
            drain();
        end

        // Asynchronous reset in the middle of digit 2.
        repeat (36) @(negedge clk);
        check_out("t6_pre_reset_digit2", 4'b1011, 4'h2, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_out("t6_async_reset", 4'hF, 4'h0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_out("t6_reset_held", 4'hF, 4'h0, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        push_frame(16'h0000, 4'h0, 4'h0, 4'hF, "t6_after_reset");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
